// File: rtl/memory_bus_pkg.sv
// Shared definitions for the memory bus initiator and its arbiter.
// Holds the bus line geometry, FSM state encoding, client identifiers,
// the latched request record and the timeout counter sizing helper.
package memory_bus_pkg;

   // One bus transfer moves a whole 8-byte line
   localparam int BUS_WIDTH_BYTES = 8;
   localparam int BUS_WIDTH_BITS  = BUS_WIDTH_BYTES * 8;
   localparam int BUS_BIT_LOG     = $clog2(BUS_WIDTH_BYTES);

   // Width of the address held in a latched request; XLEN must not exceed it
   localparam int REQ_ADDR_BITS   = 32;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      REQ     = 2'd1,
      RELEASE = 2'd2
   } bus_state_e;

   // Bit position of each client in the arbiter request/grant vectors
   typedef enum logic {
      CLIENT_IFETCH = 1'b0,
      CLIENT_DATA   = 1'b1
   } client_id_e;

   typedef struct packed {
      logic                      write;
      logic [REQ_ADDR_BITS-1:0]  address;
      logic [BUS_WIDTH_BITS-1:0] data;
      client_id_e                client;
   } bus_request_t;

   // Counter must be able to hold TIMEOUT_CYCLES-1; never narrower than 1 bit
   function automatic int timeout_count_width(input int cycles);
      return (cycles < 2) ? 1 : $clog2(cycles);
   endfunction

endpackage

// File: rtl/memory_bus_if.sv
// Point-to-point memory bus between one initiator and one responder.
// The shared data lines are resolved here: the initiator's write data
// appears on 'data' only while write is high, otherwise the responder owns it.
//   initiator: drives address, read, write, initiator_data; samples data, ready, done
//   responder: samples address, read, write, data; drives responder_data, ready, done
interface memory_bus_if #(
   parameter int ADDR_WIDTH = 32
);
   localparam int BUS_WIDTH_BITS = memory_bus_pkg::BUS_WIDTH_BITS;

   logic [ADDR_WIDTH-1:0]     address;
   logic                      read;
   logic                      write;
   logic [BUS_WIDTH_BITS-1:0] initiator_data;
   logic [BUS_WIDTH_BITS-1:0] responder_data;
   logic [BUS_WIDTH_BITS-1:0] data;
   logic                      ready;
   logic                      done;

   assign data = write ? initiator_data : responder_data;

   modport initiator (
      output address, read, write, initiator_data,
      input  data, ready, done
   );

   modport responder (
      input  address, read, write, data,
      output responder_data, ready, done
   );

endinterface

// File: rtl/memory_bus_initiator_rr_arbiter.sv
// Two-way round-robin arbiter.
//   clock, reset  : clock and asynchronous active-low reset
//   request[1:0]  : bit CLIENT_IFETCH / CLIENT_DATA asks for the bus
//   accept        : the current grant was taken this cycle
//   grant[1:0]    : one-hot grant (combinational from request and pointer)
module rr_arbiter_2
   import memory_bus_pkg::*;
(
   input  logic       clock,
   input  logic       reset,
   input  logic [1:0] request,
   input  logic       accept,
   output logic [1:0] grant
);

   client_id_e last_grant;

   // On a tie the client that was not served last wins
   always_comb begin
      grant = 2'b00;
      case (request)
         2'b01:   grant = 2'b01;
         2'b10:   grant = 2'b10;
         2'b11:   grant = (last_grant == CLIENT_DATA) ? 2'b01 : 2'b10;
         default: grant = 2'b00;
      endcase
   end

   // Reset to "instruction fetch served last" so data wins the first tie
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         last_grant <= CLIENT_IFETCH;
      end else if (accept) begin
         last_grant <= grant[1] ? CLIENT_DATA : CLIENT_IFETCH;
      end
   end

endmodule

// File: rtl/memory_bus_initiator.sv
// Initiator side of memory_bus_if serving an instruction-fetch client
// (line reads) and a data client (line reads and writes), one transaction
// at a time, with round-robin arbitration and a transaction timeout.
//   clock, reset          : clock and asynchronous active-low reset
//   memory_bus            : initiator modport of the memory bus
//   ifetch_req_*          : valid/address in, accept pulse out
//   ifetch_resp_*         : valid pulse, line data, timeout error
//   data_req_*            : valid/write/address/data in, accept pulse out
//   data_resp_*           : valid pulse (reads and writes), read data, error
module memory_bus_initiator
   import memory_bus_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  logic                      clock,
   input  logic                      reset,
   memory_bus_if.initiator           memory_bus,
   input  logic                      ifetch_req_valid,
   input  logic [XLEN-1:0]           ifetch_req_address,
   output logic                      ifetch_req_accept,
   output logic                      ifetch_resp_valid,
   output logic [BUS_WIDTH_BITS-1:0] ifetch_resp_data,
   output logic                      ifetch_resp_error,
   input  logic                      data_req_valid,
   input  logic                      data_req_write,
   input  logic [XLEN-1:0]           data_req_address,
   input  logic [BUS_WIDTH_BITS-1:0] data_req_data,
   output logic                      data_req_accept,
   output logic                      data_resp_valid,
   output logic [BUS_WIDTH_BITS-1:0] data_resp_data,
   output logic                      data_resp_error
);

   localparam int               CNT_W      = timeout_count_width(TIMEOUT_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [XLEN-1:0]  ALIGN_MASK = ~XLEN'((1 << BUS_BIT_LOG) - 1);

   bus_state_e                state, next_state;
   bus_request_t              req_q, granted_req;
   logic [CNT_W-1:0]          count;
   logic [1:0]                grant;
   logic                      accept;
   logic                      handshake;
   logic                      timed_out;
   logic                      resp_pulse;
   logic                      resp_error_q;
   logic [BUS_WIDTH_BITS-1:0] resp_data_q;

   rr_arbiter_2 arbiter (
      .clock   (clock),
      .reset   (reset),
      .request ({data_req_valid, ifetch_req_valid}),
      .accept  (accept),
      .grant   (grant)
   );

   // Accept is held low while reset is asserted even if clients are requesting
   assign accept = (state == IDLE) && (grant != 2'b00) && reset;
   assign ifetch_req_accept = accept && grant[0];
   assign data_req_accept   = accept && grant[1];

   // Build the request record for whichever client won; addresses are line aligned
   always_comb begin
      granted_req = '{write: 1'b0, address: '0, data: '0, client: CLIENT_IFETCH};
      if (grant[1]) begin
         granted_req.write   = data_req_write;
         granted_req.address = REQ_ADDR_BITS'(data_req_address & ALIGN_MASK);
         granted_req.data    = data_req_write ? data_req_data : '0;
         granted_req.client  = CLIENT_DATA;
      end else begin
         granted_req.address = REQ_ADDR_BITS'(ifetch_req_address & ALIGN_MASK);
      end
   end

   // Next-state logic; only the handshake matching the request type counts
   always_comb begin
      next_state = state;
      handshake  = 1'b0;
      timed_out  = 1'b0;
      case (state)
         IDLE: begin
            if (accept) next_state = REQ;
         end
         REQ: begin
            handshake = req_q.write ? memory_bus.done : memory_bus.ready;
            timed_out = !handshake && (count == CNT_LAST);
            if (handshake || timed_out) next_state = RELEASE;
         end
         RELEASE: begin
            if (!memory_bus.ready && !memory_bus.done) next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         req_q <= '{write: 1'b0, address: '0, data: '0, client: CLIENT_IFETCH};
      end else if (accept) begin
         req_q <= granted_req;
      end
   end

   // Counts cycles spent in REQ, starting from zero on the first REQ cycle
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         count <= '0;
      end else if (state == REQ) begin
         count <= count + CNT_W'(1);
      end else begin
         count <= '0;
      end
   end

   // Response is registered on the REQ->RELEASE edge so it pulses in the first RELEASE cycle
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         resp_pulse   <= 1'b0;
         resp_error_q <= 1'b0;
         resp_data_q  <= '0;
      end else begin
         resp_pulse <= (state == REQ) && (next_state == RELEASE);
         if ((state == REQ) && (next_state == RELEASE)) begin
            resp_error_q <= timed_out;
            resp_data_q  <= (handshake && !req_q.write) ? memory_bus.data : '0;
         end
      end
   end

   assign ifetch_resp_valid = resp_pulse && (req_q.client == CLIENT_IFETCH);
   assign ifetch_resp_error = ifetch_resp_valid && resp_error_q;
   assign ifetch_resp_data  = ifetch_resp_valid ? resp_data_q : '0;
   assign data_resp_valid   = resp_pulse && (req_q.client == CLIENT_DATA);
   assign data_resp_error   = data_resp_valid && resp_error_q;
   assign data_resp_data    = data_resp_valid ? resp_data_q : '0;

   assign memory_bus.address        = req_q.address;
   assign memory_bus.read           = (state == REQ) && !req_q.write;
   assign memory_bus.write          = (state == REQ) && req_q.write;
   assign memory_bus.initiator_data = ((state == REQ) && req_q.write) ? req_q.data : '0;

endmodule

// File: tb/tb_memory_bus_initiator.sv
module tb_memory_bus_initiator;
   import memory_bus_pkg::*;

   localparam int XLEN    = 32;
   localparam int TIMEOUT = 8;
   localparam logic [BUS_WIDTH_BITS-1:0] PRELOAD_LINE = 64'hA5A5_A5A5_1122_3344;
   localparam logic [BUS_WIDTH_BITS-1:0] WRITE_LINE   = 64'hDEAD_BEEF_CAFE_F00D;

   logic                      clock = 1'b0;
   logic                      reset = 1'b0;
   logic                      ifetch_req_valid;
   logic [XLEN-1:0]           ifetch_req_address;
   logic                      ifetch_req_accept;
   logic                      ifetch_resp_valid;
   logic [BUS_WIDTH_BITS-1:0] ifetch_resp_data;
   logic                      ifetch_resp_error;
   logic                      data_req_valid;
   logic                      data_req_write;
   logic [XLEN-1:0]           data_req_address;
   logic [BUS_WIDTH_BITS-1:0] data_req_data;
   logic                      data_req_accept;
   logic                      data_resp_valid;
   logic [BUS_WIDTH_BITS-1:0] data_resp_data;
   logic                      data_resp_error;

   int vectors;
   int miscompares;

   memory_bus_if #(.ADDR_WIDTH(XLEN)) bus ();

   memory_bus_initiator #(.XLEN(XLEN), .TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clock              (clock),
      .reset              (reset),
      .memory_bus         (bus),
      .ifetch_req_valid   (ifetch_req_valid),
      .ifetch_req_address (ifetch_req_address),
      .ifetch_req_accept  (ifetch_req_accept),
      .ifetch_resp_valid  (ifetch_resp_valid),
      .ifetch_resp_data   (ifetch_resp_data),
      .ifetch_resp_error  (ifetch_resp_error),
      .data_req_valid     (data_req_valid),
      .data_req_write     (data_req_write),
      .data_req_address   (data_req_address),
      .data_req_data      (data_req_data),
      .data_req_accept    (data_req_accept),
      .data_resp_valid    (data_resp_valid),
      .data_resp_data     (data_resp_data),
      .data_resp_error    (data_resp_error)
   );

   always #5 clock = ~clock;

   // RAM-like responder: ready/done one cycle after read/write; stall suppresses both
   logic [BUS_WIDTH_BITS-1:0] mem [0:31];
   logic stall;
   logic preload;

   always @(posedge clock) begin
      if (preload) begin
         for (int i = 0; i < 32; i++) mem[i] <= '0;
         mem[8] <= PRELOAD_LINE;
      end else if (bus.write && !stall) begin
         mem[bus.address[7:3]] <= bus.data;
      end
      bus.ready          <= bus.read && !stall;
      bus.done           <= bus.write && !stall;
      bus.responder_data <= bus.read ? mem[bus.address[7:3]] : '0;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic nextCycle();
      @(negedge clock);
      #1;
   endtask

   task automatic applyStimulus(input logic iv, input logic [XLEN-1:0] ia,
                                input logic dv, input logic dw, input logic [XLEN-1:0] da,
                                input logic [BUS_WIDTH_BITS-1:0] dd);
      ifetch_req_valid   = iv;
      ifetch_req_address = ia;
      data_req_valid     = dv;
      data_req_write     = dw;
      data_req_address   = da;
      data_req_data      = dd;
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      vectors++;
      assert (observed === expected) else begin
         miscompares++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   // Bounded wait for either accept, checking the current cycle first
   task automatic waitAccept(input string tag);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         if (ifetch_req_accept || data_req_accept) seen = 1'b1;
         else nextCycle();
      end
      checkOutput({tag, "_seen"}, 64'(seen), 64'd1);
   endtask

   // Bounded wait for any response; cycles = number of cycles advanced
   task automatic waitResp(input string tag, output int cycles);
      bit seen;
      seen   = 1'b0;
      cycles = 0;
      for (int i = 0; i < 30 && !seen; i++) begin
         nextCycle();
         cycles++;
         if (ifetch_resp_valid || data_resp_valid) seen = 1'b1;
      end
      checkOutput({tag, "_seen"}, 64'(seen), 64'd1);
   endtask

   initial begin
      int  n;
      bit  expect_data;
      vectors     = 0;
      miscompares = 0;
      stall       = 1'b0;
      preload     = 1'b1;

      // Reset state, with an ifetch request already pending
      applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, '0, '0);
      reset = 1'b0;
      repeat (2) nextCycle();
      preload = 1'b0;
      checkOutput("reset_read", 64'(bus.read), 64'd0);
      checkOutput("reset_write", 64'(bus.write), 64'd0);
      checkOutput("reset_address", 64'(bus.address), 64'd0);
      checkOutput("reset_ifetch_accept", 64'(ifetch_req_accept), 64'd0);
      checkOutput("reset_resp_valid", 64'(ifetch_resp_valid | data_resp_valid), 64'd0);

      // ifetch read of 0x40: accept c0, read c1, resp c3, idle c5
      reset = 1'b1;
      #1;
      checkOutput("t1_ifetch_accept_c0", 64'(ifetch_req_accept), 64'd1);
      checkOutput("t1_data_accept_c0", 64'(data_req_accept), 64'd0);
      nextCycle();
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
      checkOutput("t1_read_c1", 64'(bus.read), 64'd1);
      checkOutput("t1_address_c1", 64'(bus.address), 64'h40);
      nextCycle();
      checkOutput("t1_no_resp_c2", 64'(ifetch_resp_valid), 64'd0);
      nextCycle();
      checkOutput("t1_resp_valid_c3", 64'(ifetch_resp_valid), 64'd1);
      checkOutput("t1_resp_data_c3", ifetch_resp_data, PRELOAD_LINE);
      checkOutput("t1_resp_error_c3", 64'(ifetch_resp_error), 64'd0);
      checkOutput("t1_data_resp_c3", 64'(data_resp_valid), 64'd0);
      checkOutput("t1_read_low_c3", 64'(bus.read), 64'd0);
      nextCycle();
      checkOutput("t1_resp_pulse_c4", 64'(ifetch_resp_valid), 64'd0);

      // Data write of 0x80 requested in c4, must not be taken before c5
      applyStimulus(1'b0, '0, 1'b1, 1'b1, 32'h80, WRITE_LINE);
      checkOutput("t2_accept_c4", 64'(data_req_accept), 64'd0);
      nextCycle();
      checkOutput("t2_accept_c5", 64'(data_req_accept), 64'd1);
      nextCycle();
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
      checkOutput("t2_write", 64'(bus.write), 64'd1);
      checkOutput("t2_read", 64'(bus.read), 64'd0);
      checkOutput("t2_bus_data", bus.data, WRITE_LINE);
      checkOutput("t2_address", 64'(bus.address), 64'h80);
      nextCycle();
      nextCycle();
      checkOutput("t2_write_resp_valid", 64'(data_resp_valid), 64'd1);
      checkOutput("t2_write_resp_error", 64'(data_resp_error), 64'd0);
      checkOutput("t2_write_resp_data", data_resp_data, 64'd0);
      checkOutput("t2_write_resp_route", 64'(ifetch_resp_valid), 64'd0);

      // Read back 0x80
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h80, '0);
      waitAccept("t2_read_accept");
      nextCycle();
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
      waitResp("t2_read_resp", n);
      checkOutput("t2_read_valid", 64'(data_resp_valid), 64'd1);
      checkOutput("t2_read_data", data_resp_data, WRITE_LINE);
      checkOutput("t2_read_error", 64'(data_resp_error), 64'd0);

      // Both clients valid continuously after a fresh reset: data, ifetch, data, ifetch
      nextCycle();
      applyStimulus(1'b1, 32'h40, 1'b1, 1'b0, 32'h80, '0);
      reset = 1'b0;
      nextCycle();
      reset = 1'b1;
      #1;
      for (int k = 0; k < 4; k++) begin
         expect_data = (k % 2 == 0);
         waitAccept("t3_accept");
         checkOutput("t3_grant_data", 64'(data_req_accept), 64'(expect_data));
         checkOutput("t3_grant_ifetch", 64'(ifetch_req_accept), 64'(!expect_data));
         nextCycle();
         waitResp("t3_resp", n);
         checkOutput("t3_latency", 64'(n), 64'd2);
         checkOutput("t3_data_resp_valid", 64'(data_resp_valid), 64'(expect_data));
         checkOutput("t3_ifetch_resp_valid", 64'(ifetch_resp_valid), 64'(!expect_data));
         if (expect_data) checkOutput("t3_data_resp_data", data_resp_data, WRITE_LINE);
         else             checkOutput("t3_ifetch_resp_data", ifetch_resp_data, PRELOAD_LINE);
         nextCycle();
      end
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);

      // Reset asserted during REQ of a read
      nextCycle();
      applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, '0, '0);
      waitAccept("t4_accept");
      nextCycle();
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
      checkOutput("t4_read_before_reset", 64'(bus.read), 64'd1);
      reset = 1'b0;
      #1;
      checkOutput("t4_read_dropped", 64'(bus.read), 64'd0);
      for (int i = 0; i < 3; i++) begin
         nextCycle();
         checkOutput("t4_no_resp", 64'(ifetch_resp_valid | data_resp_valid), 64'd0);
      end
      reset = 1'b1;
      applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, '0, '0);
      waitAccept("t4_after_accept");
      nextCycle();
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
      waitResp("t4_after_resp", n);
      checkOutput("t4_after_valid", 64'(ifetch_resp_valid), 64'd1);
      checkOutput("t4_after_data", ifetch_resp_data, PRELOAD_LINE);

      // Responder never answers: error response 8 cycles after read rises
      nextCycle();
      stall = 1'b1;
      applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, '0, '0);
      waitAccept("t5_accept");
      nextCycle();
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
      checkOutput("t5_read_rises", 64'(bus.read), 64'd1);
      waitResp("t5_resp", n);
      checkOutput("t5_timeout_cycles", 64'(n), 64'd8);
      checkOutput("t5_resp_valid", 64'(ifetch_resp_valid), 64'd1);
      checkOutput("t5_resp_error", 64'(ifetch_resp_error), 64'd1);
      checkOutput("t5_resp_data", ifetch_resp_data, 64'd0);
      checkOutput("t5_read_low", 64'(bus.read), 64'd0);
      stall = 1'b0;

      // Next request after timeout, unaligned 0x47 goes out as 0x40
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 32'h47, '0);
      waitAccept("t6_accept");
      nextCycle();
      applyStimulus(1'b0, '0, 1'b0, 1'b0, '0, '0);
      checkOutput("t6_aligned_address", 64'(bus.address), 64'h40);
      checkOutput("t6_read", 64'(bus.read), 64'd1);
      waitResp("t6_resp", n);
      checkOutput("t6_latency", 64'(n), 64'd2);
      checkOutput("t6_resp_data", data_resp_data, PRELOAD_LINE);
      checkOutput("t6_resp_error", 64'(data_resp_error), 64'd0);

      nextCycle();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/memory_bus_initiator.md
Name: memory_bus_initiator

Overview:
Initiator end of memory_bus_if: drives address/read/write/data and consumes ready/done from a responder such as the on-chip RAM.
- Serves two clients: an instruction-fetch port (read-only) and a data port (read/write).
- Round-robin arbitration between them, one outstanding bus transaction at a time.
- Returns line-wide read data, plus an error flag when a transaction times out.

Parameters:
XLEN, 32, address width of client requests
TIMEOUT_CYCLES, 64, cycles in REQ without ready/done before the transaction aborts with error
(line width taken from memory_bus.BUS_WIDTH_BITS / BUS_WIDTH_BYTES / BUS_BIT_LOG)

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
memory_bus  interface  memory_bus_if  initiator side: drives address, read, write, data (writes only); samples data, ready, done
ifetch_req_valid  input  1  instruction line read request
ifetch_req_address  input  XLEN  byte address
ifetch_req_accept  output  1  one-cycle pulse, request taken
ifetch_resp_valid  output  1  one-cycle pulse, response available
ifetch_resp_data  output  BUS_WIDTH_BITS  line data
ifetch_resp_error  output  1  qualifies resp_valid; 1 = timeout
data_req_valid  input  1  data request
data_req_write  input  1  1 = write line, 0 = read line
data_req_address  input  XLEN  byte address
data_req_data  input  BUS_WIDTH_BITS  write line
data_req_accept  output  1  as ifetch
data_resp_valid  output  1  as ifetch (also pulses for writes)
data_resp_data  output  BUS_WIDTH_BITS  read data; 0 for writes
data_resp_error  output  1  as ifetch

Behaviour:
- Reset (async assert, sync-safe deassert): state IDLE. read, write, address, all accept/resp outputs = 0. Round-robin pointer = "instr last", so data wins the first tie.
- Reset mid-transaction: in-flight request dropped with no response; bus read/write drop immediately.
- Client rules: req_valid and its fields are held stable until accept. accept is combinational from IDLE plus the arbiter grant, asserted in the same cycle. Request fields are latched at that edge.
- Address alignment: bus address = req_address with low BUS_BIT_LOG bits cleared; unaligned inputs are silently aligned.
- FSM IDLE -> REQ -> RELEASE -> IDLE:
  - IDLE: if any req_valid, grant one, latch, go REQ.
  - REQ: drive read (or write with data); count cycles.
    - read and ready=1: capture memory_bus.data, go RELEASE, resp pending.
    - write and done=1: go RELEASE, resp pending.
    - counter reaches TIMEOUT_CYCLES-1 with no handshake: go RELEASE, error pending.
  - RELEASE: read=write=0; resp_valid (+error, data) pulses in the first RELEASE cycle, to the granted client only. Stay until ready=0 and done=0, then IDLE.
- Latency (RAM responder): accept at cycle 0; read high in cycle 1; ready seen in cycle 2; resp_valid in cycle 3; IDLE in cycle 5. Back-to-back accept spacing is at least 5 cycles.
- Write data is driven onto memory_bus.data only while write=1; the bus data is otherwise left to the responder.
- Arbitration: only one valid -> that one. Both valid -> the one not granted last. The pointer updates on each accept.
- Simultaneous ready and done in REQ: respond to the one matching the request type; ignore the other.
- Timeout response: resp_data = 0, resp_error = 1.

Decomposition:
- memory_bus_pkg: state enum (IDLE/REQ/RELEASE), client_id_e (CLIENT_IFETCH, CLIENT_DATA), request struct {write, address, data, client}, timeout counter width = $clog2(TIMEOUT_CYCLES).
- Sub-module rr_arbiter_2: two requests, grant one-hot, pointer register, advance on accept.

Test Plan:
- RAM preloaded with 0x11223344 at 0x40. ifetch read of 0x40 -> accept in cycle 0, ifetch_resp_valid in cycle 3, resp_data low word 0x11223344, error 0.
- Data write of line 0xDEADBEEF.. to 0x80, then data read of 0x80 -> write resp_valid with error 0; read returns the same line.
- Both valid every cycle for 4 transactions -> grants in order data, ifetch, data, ifetch; responses routed to the matching client only.
- Stub responder never asserts ready, TIMEOUT_CYCLES=8 -> resp_valid with error=1 exactly 8 cycles after read rises; read low afterwards; next request served normally.
- reset driven low during REQ of a read -> read=0 immediately, no resp_valid, next request after reset completes correctly.
- Unaligned read address 0x47 with BUS_WIDTH_BYTES=8 -> memory_bus.address = 0x40.
